// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// NOP bubble, occupancy states and default reset PC.
package pipe_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, instruction and PC.
// Clear drops the entry to a NOP bubble but keeps the last PC.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP);
      pc    <= RESET_PC;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= INSTR_W'(NOP);
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake,
// flush, optional skid entry and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              INSTR_W  = 32,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int              SKID     = 1,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [INSTR_W-1:0] up_instr,
  input  logic [PC_W-1:0]    up_pc,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [INSTR_W-1:0] dn_instr,
  output logic [PC_W-1:0]    dn_pc,
  output logic [PC_W-1:0]    dn_pc_plus4,
  output logic [PC_W-1:0]    dn_pc_plus8,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_t state, state_nxt;

  logic up_xfer, dn_xfer;
  logic up_ready_q;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic skid_valid;
  logic [INSTR_W-1:0] skid_instr, main_d_instr;
  logic [PC_W-1:0]    skid_pc, main_d_pc;

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  assign up_ready = (SKID != 0) ? up_ready_q
                                : (!dn_valid || dn_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      up_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      up_ready_q <= (state_nxt != TWO);
    end
  end

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (up_xfer) begin
          main_load = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_load = 1'b1;
        end else if (up_xfer && SKID != 0) begin
          skid_load = 1'b1;
          state_nxt = TWO;
        end else if (dn_xfer) begin
          main_clear = 1'b1;
          state_nxt  = EMPTY;
        end
      end
      TWO: begin
        if (dn_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins; a same-cycle downstream transfer already left.
    if (flush) begin
      state_nxt  = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  assign main_d_instr = main_from_skid ? skid_instr : up_instr;
  assign main_d_pc    = main_from_skid ? skid_pc    : up_pc;

  pipe_slot #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_instr (main_d_instr),
    .d_pc    (main_d_pc),
    .valid   (dn_valid),
    .instr   (dn_instr),
    .pc      (dn_pc)
  );

  // Never loaded when SKID=0, so it trims away.
  pipe_slot #(
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_instr (up_instr),
    .d_pc    (up_pc),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .pc      (skid_pc)
  );

  assign dn_pc_plus4 = dn_pc + PC_W'(4);
  assign dn_pc_plus8 = dn_pc + PC_W'(8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (dn_valid && !dn_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  logic unused_ok;
  assign unused_ok = skid_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (SKID=1, CNT_W=4).
// Driver queues expected entries; negedge monitor pops and compares.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        up_valid, up_ready;
  logic [31:0] up_instr, up_pc;
  logic        dn_valid, dn_ready;
  logic [31:0] dn_instr, dn_pc, dn_pc_plus4, dn_pc_plus8;
  logic [3:0]  stall_cnt;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] p4;
    logic [31:0] p8;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_instr    (up_instr),
    .up_pc       (up_pc),
    .dn_valid    (dn_valid),
    .dn_ready    (dn_ready),
    .dn_instr    (dn_instr),
    .dn_pc       (dn_pc),
    .dn_pc_plus4 (dn_pc_plus4),
    .dn_pc_plus8 (dn_pc_plus8),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dn_valid"}, 32'(dn_valid), 32'd0);
    chk({tag, "_dn_instr"}, dn_instr, 32'h0);
    chk({tag, "_dn_pc"}, dn_pc, 32'h0000_3000);
    chk({tag, "_pc_plus4"}, dn_pc_plus4, 32'h0000_3004);
    chk({tag, "_pc_plus8"}, dn_pc_plus8, 32'h0000_3008);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_up_ready"}, 32'(up_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one entry, wait for acceptance, queue its expectation.
  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] e4, input logic [31:0] e8);
    int n;
    n = 0;
    up_valid = 1'b1;
    up_instr = i;
    up_pc    = p;
    @(negedge clk);
    while (!up_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got up_ready=0 want 1 within 50");
    end else begin
      q.push_back({i, p, e4, e8});
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!dn_valid) begin
      chk("bubble_nop", dn_instr, 32'h0);
    end else if (dn_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h want none", dn_instr);
      end else begin
        e = q.pop_front();
        checks++;
        if ({dn_instr, dn_pc, dn_pc_plus4, dn_pc_plus8} !== e) begin
          errors++;
          $display("FAIL out_entry: got %h/%h/%h/%h want %h/%h/%h/%h",
                   dn_instr, dn_pc, dn_pc_plus4, dn_pc_plus8,
                   e.i, e.p, e.p4, e.p8);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    up_instr = '0;
    up_pc    = '0;
    dn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset("rst");

    // Streaming at full rate
    send(32'h0000_0A01, 32'h0000_3000, 32'h0000_3004, 32'h0000_3008);
    send(32'h0000_0B02, 32'h0000_3004, 32'h0000_3008, 32'h0000_300C);
    send(32'h0000_0C03, 32'h0000_3008, 32'h0000_300C, 32'h0000_3010);
    idle(3);

    // Reset mid-cycle while an entry is held
    dn_ready = 1'b0;
    send(32'h0000_0D04, 32'h0000_4000, 32'h0000_4004, 32'h0000_4008);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_reset("midrst");
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    dn_ready = 1'b1;

    // Skid: three stall cycles
    up_valid = 1'b1;
    up_instr = 32'h0000_1A01;
    up_pc    = 32'h0000_5000;
    q.push_back({32'h0000_1A01, 32'h0000_5000, 32'h0000_5004, 32'h0000_5008});
    idle(1);
    dn_ready = 1'b0;
    up_instr = 32'h0000_1B02;
    up_pc    = 32'h0000_5004;
    q.push_back({32'h0000_1B02, 32'h0000_5004, 32'h0000_5008, 32'h0000_500C});
    idle(1);
    up_instr = 32'h0000_1C03;
    up_pc    = 32'h0000_5008;
    chk("skid_up_ready_1", 32'(up_ready), 32'd0);
    chk("skid_head_1", dn_instr, 32'h0000_1A01);
    idle(1);
    chk("skid_up_ready_2", 32'(up_ready), 32'd0);
    chk("skid_head_2", dn_instr, 32'h0000_1A01);
    idle(1);
    chk("skid_stall_cnt", 32'(stall_cnt), 32'd3);
    dn_ready = 1'b1;
    idle(1);
    chk("skid_up_ready_back", 32'(up_ready), 32'd1);
    chk("skid_head_b", dn_instr, 32'h0000_1B02);
    q.push_back({32'h0000_1C03, 32'h0000_5008, 32'h0000_500C, 32'h0000_5010});
    idle(1);
    up_valid = 1'b0;
    idle(2);
    chk("skid_stall_cnt_hold", 32'(stall_cnt), 32'd3);

    // Flush in TWO with an incoming entry
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_instr = 32'h0000_2A01;
    up_pc    = 32'h0000_6000;
    idle(1);
    up_instr = 32'h0000_2B02;
    up_pc    = 32'h0000_6004;
    idle(1);
    up_instr = 32'h0000_2C03;
    up_pc    = 32'h0000_6008;
    flush    = 1'b1;
    idle(1);
    flush    = 1'b0;
    up_valid = 1'b0;
    chk("flush_dn_valid", 32'(dn_valid), 32'd0);
    chk("flush_dn_instr", dn_instr, 32'h0);
    chk("flush_dn_pc", dn_pc, 32'h0000_6000);
    chk("flush_up_ready", 32'(up_ready), 32'd1);
    chk("flush_keeps_cnt", 32'(stall_cnt), 32'd5);
    dn_ready = 1'b1;
    idle(3);
    chk("flush_pc_hold", dn_pc, 32'h0000_6000);

    // PC wrap
    send(32'h0000_3A01, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004);
    idle(2);

    // Saturation: 20 stall cycles from a count of 5
    dn_ready = 1'b0;
    send(32'h0000_4A01, 32'h0000_7000, 32'h0000_7004, 32'h0000_7008);
    idle(20);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_head", dn_instr, 32'h0000_4A01);
    dn_ready = 1'b1;
    idle(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
